// File: rtl/onehot_issue_sequencer.sv
// One-hot issue sequencer: buffers bit-index requests and issues them in order
// as a registered one-hot vector. Optional macro: ONEHOT_SEQ_DUP_FILTER_EN.
module onehot_issue_sequencer #(
    parameter int WIDTH    = 10440,
    parameter int IDX_W    = 14,
    parameter int DEPTH    = 4,
    parameter int DEP_IDX  = 9908,
    parameter int DEP_A    = 10370,
    parameter int DEP_B    = 10425,
    parameter int DEP_C    = 2352,
    parameter int IDLE_IDX = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] shadow,
    output logic             all_done,
    output logic             blocked,
    output logic             err_range,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_BLOCKED = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [IDX_W:0]   WIDTH_L = (IDX_W+1)'(WIDTH);
    localparam logic [IDX_W-1:0] DEP_L   = IDX_W'(DEP_IDX);
    localparam logic [PTR_W:0]   FULL_L  = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] x_out_q, x_out_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             err_range_q, err_range_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0] head;
    logic             empty;
    logic             full;
    logic             prereq;
    logic [1:0]       state;
    logic             accept;
    logic             in_range;
    logic             pop;
    logic             push;
    logic             dup_hit;
    logic [WIDTH-1:0] issue_vec;

    // Queue status and the state derived from registered occupancy/shadow.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        empty    = (count_q == '0);
        full     = (count_q == FULL_L);
        prereq   = shadow_q[DEP_A] | shadow_q[DEP_B] | shadow_q[DEP_C];
        all_done = &shadow_q;
        blocked  = !empty && (head == DEP_L) && !prereq;
        if (all_done)
            state = S_DONE;
        else if (empty)
            state = S_IDLE;
        else if (blocked)
            state = S_BLOCKED;
        else
            state = S_ISSUE;
    end

    // Handshake, pop/push decisions and the duplicate filter.
    always_comb begin
        in_ready  = (state == S_DONE) || !full;
        accept    = in_valid && in_ready;
        in_range  = ({1'b0, in_idx} < WIDTH_L);
        pop       = (state == S_ISSUE);
        issue_vec = pop ? (WIDTH'(1) << head) : '0;
`ifdef ONEHOT_SEQ_DUP_FILTER_EN
        // Compare against the shadow as it will be after this cycle's issue.
        dup_hit   = in_range && ((shadow_q | issue_vec) >> in_idx) != '0
                    && (((shadow_q | issue_vec) >> in_idx) & WIDTH'(1)) != '0;
`else
        dup_hit   = 1'b0;
`endif
        push      = accept && in_range && (state != S_DONE) && !dup_hit;
    end

    // Next-state values for the output vector, shadow, counter and FIFO.
    always_comb begin
        x_out_d     = pop ? (WIDTH'(1) << head) : x_out_q;
        shadow_d    = shadow_q | issue_vec;
        err_range_d = accept && !in_range;
        issue_cnt_d = issue_cnt_q;
        if (pop && (issue_cnt_q != '1))
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        mem_d    = mem_q;
        if (push)
            mem_d[wr_ptr_q] = in_idx;
    end

    // Control state with synchronous reset; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_out_q     <= WIDTH'(1) << IDLE_IDX;
            shadow_q    <= '0;
            err_range_q <= 1'b0;
            issue_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            x_out_q     <= x_out_d;
            shadow_q    <= shadow_d;
            err_range_q <= err_range_d;
            issue_cnt_q <= issue_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage needs no reset; occupancy alone marks valid entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign x_out     = x_out_q;
    assign shadow    = shadow_q;
    assign err_range = err_range_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_onehot_issue_sequencer.sv
// Randomized scoreboard bench for onehot_issue_sequencer; a queue-based
// reference model predicts every issue, status output and handshake.
module tb_onehot_issue_sequencer;

    localparam int W     = 10440;
    localparam int IW    = 14;
    localparam int DEPTH = 4;
    localparam int DEP   = 9908;
    localparam int DA    = 10370;
    localparam int DB    = 10425;
    localparam int DC    = 2352;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_idx = '0;
    logic [W-1:0]  x_out;
    logic [W-1:0]  shadow;
    logic          all_done;
    logic          blocked;
    logic          err_range;
    logic [CW-1:0] issue_cnt;

    int checks = 0;
    int failures = 0;

    onehot_issue_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .x_out     (x_out),
        .shadow    (shadow),
        .all_done  (all_done),
        .blocked   (blocked),
        .err_range (err_range),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic ok,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    function automatic int lowest(input logic [W-1:0] v);
        for (int i = 0; i < W; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: pending requests in order, set of issued bits,
    // index last issued, pop count and expected error pulse.
    int           q[$];
    logic [W-1:0] shm;
    int           nset;
    int           xexp;
    int           cntm;
    logic         errm;
    logic         started = 1'b0;

    function automatic logic m_blocked();
        return q.size() > 0 && q[0] == DEP && !(shm[DA] || shm[DB] || shm[DC]);
    endfunction

    // Monitor: advance the model over the edge just passed, then compare.
    always @(negedge clk) begin
        logic         done_m;
        logic         acc;
        logic         inr;
        logic         drop;
        int           h;
        int           idx;
        logic [W-1:0] xv;
        if (rst) begin
            started = 1'b1;
            q.delete();
            shm  = '0;
            nset = 0;
            xexp = 0;
            cntm = 0;
            errm = 1'b0;
        end else if (started) begin
            done_m = (nset == W);
            idx    = int'(in_idx);
            acc    = in_valid && (done_m || q.size() < DEPTH);
            inr    = idx < W;
            errm   = acc && !inr;
            if (!done_m && q.size() > 0 && !m_blocked()) begin
                h = q.pop_front();
                xexp = h;
                if (!shm[h]) begin
                    shm[h] = 1'b1;
                    nset++;
                end
                if (cntm < (1 << CW) - 1) cntm++;
            end
            if (acc && inr && !done_m) begin
                drop = 1'b0;
`ifdef ONEHOT_SEQ_DUP_FILTER_EN
                drop = shm[idx];
`endif
                if (!drop) q.push_back(idx);
            end
        end
        if (started) begin
            xv = '0;
            xv[xexp] = 1'b1;
            chk("x_out", x_out == xv, lowest(x_out), xexp);
            chk("x_out_onehot", $countones(x_out) == 1, $countones(x_out), 1);
            chk("shadow", shadow == shm, $countones(shadow), $countones(shm));
            chk("issue_cnt", issue_cnt == CW'(cntm), issue_cnt, cntm);
            chk("err_range", err_range == errm, err_range, errm);
            chk("in_ready", in_ready == ((nset == W) || q.size() < DEPTH),
                in_ready, (nset == W) || q.size() < DEPTH);
            chk("blocked", blocked == m_blocked(), blocked, m_blocked());
            chk("all_done", all_done == (nset == W), all_done, nset == W);
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic push(input int idx);
        logic ok;
        int   b;
        b = 0;
        in_valid = 1'b1;
        in_idx   = IW'(idx);
        forever begin
            ok = in_ready;
            step();
            if (ok) break;
            b++;
            if (b > 200) begin
                checks++;
                failures++;
                $display("FAIL push_timeout idx=%0d: got no accept want accept", idx);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic attempt(input int idx);
        in_valid = 1'b1;
        in_idx   = IW'(idx);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #2;
        do_reset();
        idle(5);

        push(5);
        push(7);
        idle(4);

        do_reset();
        push(DEP);
        repeat (8) attempt(int'($urandom_range(0, 200)));
        idle(4);

        do_reset();
        push(DC);
        push(DEP);
        idle(3);

        attempt(W);
        attempt(int'($urandom_range(W, (1 << IW) - 1)));
        idle(2);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60)
                attempt(int'($urandom_range(0, W - 1)));
            else if (r < 65)
                attempt(int'($urandom_range(W, (1 << IW) - 1)));
            else if (r < 75)
                attempt(12);
            else
                idle(1);
        end
        idle(6);
        push(12);
        push(12);
        push(12);
        idle(4);

        do_reset();
        push(DC);
        for (int i = 0; i < W; i++)
            if (i != DC) push(i);
        idle(4);
        push(5);
        push(W - 1);
        push(100);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
